// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg -- definitions shared by spi_master, its interface and its benches.
//   SPI_BYTE_W  : bits per SPI slot
//   spi_state_e : master FSM state encoding
// ---------------------------------------------------------------------------
package spi_pkg;

    localparam int unsigned SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_H,
        SCK_L,
        HOLD,
        TRAIL,
        GAP
    } spi_state_e;

endpackage

// File: rtl/spi_master_if.sv
// ---------------------------------------------------------------------------
// spi_master_if -- bundles the SPI bus pins and the parent-side byte
// handshake of spi_master.
//   SPI bus   : spi_clk_o, spi_csn_o, spi_mosi_o (master out), spi_miso_i (in)
//   handshake : tx_byte_i, tx_last_i, start_i (in); ready_o, rx_byte_o,
//               rx_en_o, busy_o (out)
//   modport master : the spi_master view
//   modport slave  : the view of the parent logic / peripheral side
// ---------------------------------------------------------------------------
interface spi_master_if;
    import spi_pkg::*;

    logic                  spi_clk_o;
    logic                  spi_csn_o;
    logic                  spi_mosi_o;
    logic                  spi_miso_i;
    logic [SPI_BYTE_W-1:0] tx_byte_i;
    logic                  tx_last_i;
    logic                  start_i;
    logic                  ready_o;
    logic [SPI_BYTE_W-1:0] rx_byte_o;
    logic                  rx_en_o;
    logic                  busy_o;

    modport master (
        output spi_clk_o, spi_csn_o, spi_mosi_o,
        input  spi_miso_i,
        input  tx_byte_i, tx_last_i, start_i,
        output ready_o, rx_byte_o, rx_en_o, busy_o
    );

    modport slave (
        input  spi_clk_o, spi_csn_o, spi_mosi_o,
        output spi_miso_i,
        output tx_byte_i, tx_last_i, start_i,
        input  ready_o, rx_byte_o, rx_en_o, busy_o
    );

endinterface

// File: rtl/spi_clkdiv.sv
// ---------------------------------------------------------------------------
// spi_clkdiv -- reloadable half-period down-counter.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : reload to DIV-1 (asserted on every FSM state change)
//   tick_o        : counter at 0, i.e. the current state has lasted DIV cycles
// Parameter DIV: half-period in clock cycles, 2..255.
// ---------------------------------------------------------------------------
module spi_clkdiv #(
    parameter int unsigned DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    output logic tick_o
);

    localparam logic [7:0] RELOAD = 8'(DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master -- byte-oriented SPI mode-0 master (CPOL=0, CPHA=0).
//   clk6x  : system clock
//   resetn : async active-low reset
//   bus    : spi_master_if.master (SPI pins + byte handshake)
// One byte is accepted per start_i while ready_o; the byte received in that
// slot is returned on rx_byte_o with a one-cycle rx_en_o. CSN stays low
// across bytes until a byte flagged tx_last_i completes.
// Build option: SPI_MASTER_LSB_FIRST_EN reverses bit order in both
// directions (default MSB first); timing is unchanged.
// ---------------------------------------------------------------------------
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic         clk6x,
    input  logic         resetn,
    spi_master_if.master bus
);

    spi_state_e            state_q, state_d;
    logic [SPI_BYTE_W-1:0] tx_q, tx_d;
    logic [SPI_BYTE_W-1:0] rx_sh_q, rx_sh_d;
    logic [SPI_BYTE_W-1:0] rx_byte_q, rx_byte_d;
    logic                  rx_en_q, rx_en_d;
    logic                  last_q, last_d;
    logic [2:0]            bit_q, bit_d;
    logic                  tick;
    logic                  load;
    logic [SPI_BYTE_W-1:0] tx_shifted;
    logic [SPI_BYTE_W-1:0] rx_shifted;
    logic                  mosi;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign mosi       = tx_q[0];
    assign tx_shifted = {1'b0, tx_q[SPI_BYTE_W-1:1]};
    assign rx_shifted = {bus.spi_miso_i, rx_sh_q[SPI_BYTE_W-1:1]};
`else
    assign mosi       = tx_q[SPI_BYTE_W-1];
    assign tx_shifted = {tx_q[SPI_BYTE_W-2:0], 1'b0};
    assign rx_shifted = {rx_sh_q[SPI_BYTE_W-2:0], bus.spi_miso_i};
`endif

    // Every state change reloads the divider, so each timed state lasts DIV cycles.
    assign load = (state_d != state_q);

    spi_clkdiv #(
        .DIV (DIV)
    ) u_clkdiv (
        .clk_i  (clk6x),
        .rst_ni (resetn),
        .load_i (load),
        .tick_o (tick)
    );

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_byte_d = rx_byte_q;
        rx_en_d   = 1'b0;
        last_d    = last_q;
        bit_d     = bit_q;
        unique case (state_q)
            IDLE, HOLD: begin
                if (bus.start_i) begin
                    tx_d    = bus.tx_byte_i;
                    last_d  = bus.tx_last_i;
                    bit_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) state_d = SCK_H;
            end
            SCK_H: begin
                // MISO sampled on the SCK fall edge; TX shift on SCK_L entry.
                if (tick) begin
                    rx_sh_d = rx_shifted;
                    tx_d    = tx_shifted;
                    state_d = SCK_L;
                end
            end
            SCK_L: begin
                if (tick) begin
                    if (bit_q != 3'd7) begin
                        bit_d   = bit_q + 3'd1;
                        state_d = SCK_H;
                    end else begin
                        rx_byte_d = rx_sh_q;
                        rx_en_d   = 1'b1;
                        state_d   = last_q ? TRAIL : HOLD;
                    end
                end
            end
            TRAIL: begin
                if (tick) state_d = GAP;
            end
            GAP: begin
                if (tick) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_byte_q <= '0;
            rx_en_q   <= 1'b0;
            last_q    <= 1'b0;
            bit_q     <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_byte_q <= rx_byte_d;
            rx_en_q   <= rx_en_d;
            last_q    <= last_d;
            bit_q     <= bit_d;
        end
    end

    assign bus.spi_clk_o  = (state_q == SCK_H);
    assign bus.spi_csn_o  = (state_q == IDLE) || (state_q == GAP);
    assign bus.spi_mosi_o = mosi;
    assign bus.ready_o    = (state_q == IDLE) || (state_q == HOLD);
    assign bus.busy_o     = (state_q != IDLE);
    assign bus.rx_byte_o  = rx_byte_q;
    assign bus.rx_en_o    = rx_en_q;

endmodule

// File: tb/tb_spi_master.sv
// ---------------------------------------------------------------------------
// tb_spi_master -- self-checking bench for spi_master (DIV=4).
// Expected rx bytes go into a scoreboard when a byte is launched and are
// compared against the bytes captured on rx_en_o. Honours
// SPI_MASTER_LSB_FIRST_EN for the wire-order expectations.
// ---------------------------------------------------------------------------
module tb_spi_master;
    import spi_pkg::*;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    spi_master_if bus ();

    spi_master #(.DIV(DIV)) dut (
        .clk6x  (clk),
        .resetn (rstn),
        .bus    (bus.master)
    );

    // Loopback or a simple mode-0 slave shifting out on SCK fall.
    logic       loop_en    = 1'b1;
    logic       slave_load = 1'b0;
    logic [7:0] slave_val  = '0;
    logic [7:0] slave_sh   = '0;
    logic       sck_d      = 1'b0;
    assign bus.spi_miso_i = loop_en ? bus.spi_mosi_o : slave_sh[7];

    always @(posedge clk) begin
        sck_d <= bus.spi_clk_o;
        if (slave_load) slave_sh <= slave_val;
        else if (sck_d && !bus.spi_clk_o) slave_sh <= {slave_sh[6:0], 1'b0};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records events with the cycle they were seen in.
    int         rise_cyc[$];
    logic [7:0] rx_obs[$];
    logic [7:0] mosi_cap     = '0;
    logic       sck_prev     = 1'b0;
    logic       csn_prev     = 1'b1;
    logic       busy_prev    = 1'b0;
    int         rx_cyc       = 0;
    int         csn_rises    = 0;
    int         csn_rise_cyc = 0;
    int         busy_fall_cyc = 0;

    always @(negedge clk) begin
        if (bus.spi_clk_o && !sck_prev) begin
            rise_cyc.push_back(cyc);
            mosi_cap <= {mosi_cap[6:0], bus.spi_mosi_o};
        end
        if (bus.rx_en_o) begin
            rx_obs.push_back(bus.rx_byte_o);
            rx_cyc <= cyc;
        end
        if (bus.spi_csn_o && !csn_prev) begin
            csn_rises    <= csn_rises + 1;
            csn_rise_cyc <= cyc;
        end
        if (!bus.busy_o && busy_prev) busy_fall_cyc <= cyc;
        sck_prev  <= bus.spi_clk_o;
        csn_prev  <= bus.spi_csn_o;
        busy_prev <= bus.busy_o;
    end

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sb[$];
    int         rx_rd    = 0;
    int         e0       = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] wire_order(input logic [7:0] b);
        logic [7:0] r;
`ifdef SPI_MASTER_LSB_FIRST_EN
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
`else
        r = b;
`endif
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic last, input logic push,
                             input logic [7:0] exp_rx);
        int n = 0;
        @(negedge clk);
        while (!bus.ready_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait_timeout", 32'(n >= 2000), 32'd0);
        bus.start_i   = 1'b1;
        bus.tx_byte_i = b;
        bus.tx_last_i = last;
        if (push) sb.push_back(exp_rx);
        e0 = cyc + 1;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy_o && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait_timeout", 32'(n >= 4000), 32'd0);
        @(negedge clk);
    endtask

    // Compare every captured rx byte against the scoreboard head.
    task automatic drain(input string tag);
        while (rx_rd < rx_obs.size()) begin
            if (sb.size() == 0) begin
                check({tag, "_unexpected_rx"}, 32'(rx_obs[rx_rd]), 32'hFFFF_FFFF);
            end else begin
                check({tag, "_rx_byte"}, 32'(rx_obs[rx_rd]), 32'(sb.pop_front()));
            end
            rx_rd++;
        end
        check({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int r0, x0, c0, n;
        bus.start_i   = 1'b0;
        bus.tx_byte_i = '0;
        bus.tx_last_i = 1'b0;

        // Reset values
        #3;
        check("rst_csn",   32'(bus.spi_csn_o),  32'd1);
        check("rst_sck",   32'(bus.spi_clk_o),  32'd0);
        check("rst_mosi",  32'(bus.spi_mosi_o), 32'd0);
        check("rst_rxb",   32'(bus.rx_byte_o),  32'd0);
        check("rst_rxen",  32'(bus.rx_en_o),    32'd0);
        check("rst_busy",  32'(bus.busy_o),     32'd0);
        check("rst_ready", 32'(bus.ready_o),    32'd1);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single byte loopback with timing
        r0 = rise_cyc.size(); x0 = rx_obs.size(); c0 = csn_rises;
        send_byte(8'hA5, 1'b1, 1'b1, 8'hA5);
        wait_idle();
        check("t1_rises",     32'(rise_cyc.size() - r0), 32'd8);
        check("t1_first_sck", 32'(rise_cyc[r0] - e0), 32'(DIV));
        check("t1_sck_per",   32'(rise_cyc[r0+1] - rise_cyc[r0]), 32'(2*DIV));
        check("t1_rx_lat",    32'(rx_cyc - e0), 32'(17*DIV));
        check("t1_csn_rise",  32'(csn_rise_cyc - e0), 32'(18*DIV));
        check("t1_busy_fall", 32'(busy_fall_cyc - e0), 32'(19*DIV));
        check("t1_rx_cnt",    32'(rx_obs.size() - x0), 32'd1);
        check("t1_csn_cnt",   32'(csn_rises - c0), 32'd1);
        check("t1_mosi",      32'(mosi_cap), 32'(wire_order(8'hA5)));
        drain("t1");

        // 2: 3-byte burst, CSN held low throughout
        r0 = rise_cyc.size(); x0 = rx_obs.size(); c0 = csn_rises;
        send_byte(8'h01, 1'b0, 1'b1, 8'h01);
        send_byte(8'h20, 1'b0, 1'b1, 8'h20);
        send_byte(8'h80, 1'b1, 1'b1, 8'h80);
        wait_idle();
        check("t2_rises",   32'(rise_cyc.size() - r0), 32'd24);
        check("t2_rx_cnt",  32'(rx_obs.size() - x0), 32'd3);
        check("t2_csn_cnt", 32'(csn_rises - c0), 32'd1);
        check("t2_mosi",    32'(mosi_cap), 32'(wire_order(8'h80)));
        drain("t2");

        // 3: slave drives 0x3C while master sends 0xFF
        @(negedge clk);
        slave_val  = 8'h3C;
        slave_load = 1'b1;
        @(negedge clk);
        slave_load = 1'b0;
        loop_en    = 1'b0;
        send_byte(8'hFF, 1'b1, 1'b1, wire_order(8'h3C));
        wait_idle();
        loop_en = 1'b1;
        check("t3_mosi", 32'(mosi_cap), 32'hFF);
        drain("t3");

        // 4: start_i during a byte is ignored
        r0 = rise_cyc.size(); x0 = rx_obs.size();
        send_byte(8'hC4, 1'b1, 1'b1, 8'hC4);
        repeat (20) @(negedge clk);
        bus.start_i   = 1'b1;
        bus.tx_byte_i = 8'h55;
        bus.tx_last_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk);
        check("t4_busy",   32'(bus.busy_o), 32'd0);
        check("t4_rises",  32'(rise_cyc.size() - r0), 32'd8);
        check("t4_rx_cnt", 32'(rx_obs.size() - x0), 32'd1);
        check("t4_mosi",   32'(mosi_cap), 32'(wire_order(8'hC4)));
        drain("t4");

        // 5: reset after the 3rd SCK rise, then a clean transfer
        r0 = rise_cyc.size(); x0 = rx_obs.size();
        send_byte(8'h96, 1'b1, 1'b0, 8'h00);
        n = 0;
        while (rise_cyc.size() - r0 < 3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t5_rise_wait_timeout", 32'(n >= 2000), 32'd0);
        rstn = 1'b0;
        #1;
        check("t5_csn",   32'(bus.spi_csn_o),  32'd1);
        check("t5_sck",   32'(bus.spi_clk_o),  32'd0);
        check("t5_mosi",  32'(bus.spi_mosi_o), 32'd0);
        check("t5_rxb",   32'(bus.rx_byte_o),  32'd0);
        check("t5_busy",  32'(bus.busy_o),     32'd0);
        check("t5_ready", 32'(bus.ready_o),    32'd1);
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_no_rx", 32'(rx_obs.size() - x0), 32'd0);
        r0 = rise_cyc.size();
        send_byte(8'h5A, 1'b1, 1'b1, 8'h5A);
        wait_idle();
        check("t5_rises", 32'(rise_cyc.size() - r0), 32'd8);
        check("t5_mosi2", 32'(mosi_cap), 32'(wire_order(8'h5A)));
        drain("t5");

        // 6: 0x01 loopback exposes bit order on the wire
        send_byte(8'h01, 1'b1, 1'b1, 8'h01);
        wait_idle();
`ifdef SPI_MASTER_LSB_FIRST_EN
        check("t6_mosi_lsb", 32'(mosi_cap), 32'h80);
`else
        check("t6_mosi_msb", 32'(mosi_cap), 32'h01);
`endif
        drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
